// File: rtl/acc_drain.sv
// acc_drain: snapshots an N x N bank of signed accumulators on start_i and
// streams them out row-major over valid/ready. Each element is passed
// through an optional ReLU and then saturated to OUT_WIDTH.
module acc_drain #(
  parameter int N         = 4,
  parameter int ACC_WIDTH = 17,
  parameter int OUT_WIDTH = 9,
  parameter int RELU_EN   = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start_i,
  input  logic [N*N*ACC_WIDTH-1:0]      acc_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic signed [OUT_WIDTH-1:0]   out_data_o,
  output logic [$clog2(N)-1:0]          out_row_o,
  output logic [$clog2(N)-1:0]          out_col_o,
  output logic                          out_last_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Saturation bounds expressed at accumulator width so comparisons stay signed.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   row_reg, row_next;
  logic [IW-1:0]   col_reg, col_next;
  logic            capture;
  logic            stream_active;

  // Post-processed value of every snapshot element, indexed [row][col].
  logic signed [OUT_WIDTH-1:0] proc_arr [N][N];

  genvar gi;
  generate
    for (gi = 0; gi < N*N; gi++) begin : g_elem
      logic signed [ACC_WIDTH-1:0] snap_reg;
      logic signed [ACC_WIDTH-1:0] relu_val;
      logic signed [OUT_WIDTH-1:0] proc_val;

      // Snapshot capture: all elements load together on the accepted start.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          snap_reg <= '0;
        end else if (capture) begin
          snap_reg <= acc_i[gi*ACC_WIDTH +: ACC_WIDTH];
        end
      end

      // ReLU followed by saturation to the output width.
      always_comb begin
        relu_val = snap_reg;
        if ((RELU_EN != 0) && snap_reg[ACC_WIDTH-1]) begin
          relu_val = '0;
        end
        if (relu_val > SAT_MAX) begin
          proc_val = OUT_MAX;
        end else if (relu_val < SAT_MIN) begin
          proc_val = OUT_MIN;
        end else begin
          proc_val = relu_val[OUT_WIDTH-1:0];
        end
      end

      assign proc_arr[gi / N][gi % N] = proc_val;
    end
  endgenerate

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
    end
  end

  // Next-state and counter logic; counters advance only on a transfer.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          capture    = 1'b1;
          row_next   = '0;
          col_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (out_ready_i) begin
          if (col_reg == LAST_IDX) begin
            col_next = '0;
            if (row_reg == LAST_IDX) begin
              row_next   = '0;
              state_next = DONE;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      DONE: begin
        row_next   = '0;
        col_next   = '0;
        state_next = IDLE;
      end
      default: begin
        row_next   = '0;
        col_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Output decode; everything is held at zero outside STREAM.
  always_comb begin
    stream_active = (state_reg == STREAM);
    busy_o        = stream_active;
    out_valid_o   = stream_active;
    done_o        = (state_reg == DONE);
    out_data_o    = '0;
    out_row_o     = '0;
    out_col_o     = '0;
    out_last_o    = 1'b0;
    if (stream_active) begin
      out_data_o = proc_arr[row_reg][col_reg];
      out_row_o  = row_reg;
      out_col_o  = col_reg;
      out_last_o = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain with N=2: one instance with ReLU, one bypassing it,
// sharing all inputs. Expected elements are queued at start; a monitor
// pops and compares on every handshake.
module tb_acc_drain;

  localparam int N    = 2;
  localparam int ACCW = 17;
  localparam int OUTW = 9;

  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic ready;
  logic [N*N*ACCW-1:0] acc_in;

  logic r_busy, r_done, r_valid, r_last;
  logic signed [OUTW-1:0] r_data;
  logic [0:0] r_row, r_col;
  logic b_busy, b_done, b_valid, b_last;
  logic signed [OUTW-1:0] b_data;
  logic [0:0] b_row, b_col;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int dr;
    int db;
    int row;
    int col;
    int last;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  acc_drain #(.N(N), .ACC_WIDTH(ACCW), .OUT_WIDTH(OUTW), .RELU_EN(1)) u_relu (
    .clk(clk), .rstn(rstn), .start_i(start), .acc_i(acc_in),
    .busy_o(r_busy), .done_o(r_done), .out_valid_o(r_valid), .out_ready_i(ready),
    .out_data_o(r_data), .out_row_o(r_row), .out_col_o(r_col), .out_last_o(r_last)
  );

  acc_drain #(.N(N), .ACC_WIDTH(ACCW), .OUT_WIDTH(OUTW), .RELU_EN(0)) u_bypass (
    .clk(clk), .rstn(rstn), .start_i(start), .acc_i(acc_in),
    .busy_o(b_busy), .done_o(b_done), .out_valid_o(b_valid), .out_ready_i(ready),
    .out_data_o(b_data), .out_row_o(b_row), .out_col_o(b_col), .out_last_o(b_last)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*N*ACCW-1:0] pack4(input int e00, input int e01,
                                                input int e10, input int e11);
    logic [ACCW-1:0] a, b, c, d;
    a = e00[ACCW-1:0];
    b = e01[ACCW-1:0];
    c = e10[ACCW-1:0];
    d = e11[ACCW-1:0];
    return {d, c, b, a};
  endfunction

  task automatic push(input int dr, input int db, input int row, input int col, input int last);
    exp_t e;
    e.dr = dr; e.db = db; e.row = row; e.col = col; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_busy"},  {31'd0, r_busy} | {31'd0, b_busy}, 0);
    chk({name, "_done"},  {31'd0, r_done} | {31'd0, b_done}, 0);
    chk({name, "_valid"}, {31'd0, r_valid} | {31'd0, b_valid}, 0);
    chk({name, "_data"},  $signed(r_data) | $signed(b_data), 0);
    chk({name, "_idx"},   {30'd0, r_row, r_col} | {30'd0, b_row, b_col}, 0);
    chk({name, "_last"},  {31'd0, r_last} | {31'd0, b_last}, 0);
  endtask

  // Monitor: one line per transfer, compared against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn === 1'b1 && r_valid === 1'b1 && ready === 1'b1) begin
      chk("valid_match", {31'd0, b_valid}, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("xfer row=%0d col=%0d relu=%0d bypass=%0d last=%0d",
                 r_row, r_col, $signed(r_data), $signed(b_data), r_last);
        chk("data_relu", $signed(r_data), e.dr);
        chk("data_bypass", $signed(b_data), e.db);
        chk("row", {31'd0, r_row}, e.row);
        chk("col", {31'd0, r_col}, e.col);
        chk("last", {31'd0, r_last}, e.last);
        chk("idx_bypass", {30'd0, b_row, b_col}, e.row * 2 + e.col);
      end
    end
  end

  // One drain: start, optional stall at element (0,1), optional acc/start poke.
  task automatic drain(input logic [N*N*ACCW-1:0] acc, input int stall_len,
                       input bit poke, input bit tail, input string name);
    int cyc;
    int done_at;
    bit stalled;
    @(posedge clk); #1;
    acc_in = acc;
    start  = 1'b1;
    ready  = 1'b1;
    cyc = 0;
    done_at = -1;
    while (done_at < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (poke && cyc == 1) acc_in = '1;
      if (poke && cyc == 2) start = 1'b1;
      stalled = (stall_len > 0) && (cyc >= 2) && (cyc < 2 + stall_len);
      ready = !stalled;
      @(negedge clk);
      if (stalled) begin
        chk({name, "_stall_valid"}, {31'd0, r_valid}, 1);
        chk({name, "_stall_idx"}, {30'd0, r_row, r_col}, 1);
        chk({name, "_stall_relu"}, $signed(r_data), 0);
        chk({name, "_stall_bypass"}, $signed(b_data), -7);
      end
      if (r_done === 1'b1) begin
        done_at = cyc;
        chk({name, "_done_busy"}, {31'd0, r_busy}, 0);
        chk({name, "_done_valid"}, {31'd0, r_valid}, 0);
        chk({name, "_done_bypass"}, {31'd0, b_done}, 1);
      end else begin
        chk({name, "_busy"}, {31'd0, r_busy}, 1);
      end
    end
    $display("drain %s done_cycle=%0d", name, done_at);
    chk({name, "_done_cycle"}, done_at, 5 + stall_len);
    if (tail) begin
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk({name, "_tail_done"}, {31'd0, r_done}, 0);
        chk({name, "_tail_valid"}, {31'd0, r_valid}, 0);
      end
    end
  endtask

  initial begin
    rstn   = 1'b0;
    start  = 1'b0;
    ready  = 1'b0;
    acc_in = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic drain, ready held high: ReLU and bypass results side by side.
    push(5, 5, 0, 0, 0);
    push(0, -7, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    drain(pack4(5, -7, 300, -300), 0, 1'b0, 1'b1, "basic");

    // Backpressure for three cycles at element (0,1).
    push(5, 5, 0, 0, 0);
    push(0, -7, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    drain(pack4(5, -7, 300, -300), 3, 1'b0, 1'b1, "backpressure");

    // Snapshot isolation plus a start pulse while streaming.
    push(5, 5, 0, 0, 0);
    push(0, -7, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    drain(pack4(5, -7, 300, -300), 0, 1'b1, 1'b1, "isolation");

    // Reset after two transfers.
    push(5, 5, 0, 0, 0);
    push(0, -7, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    @(posedge clk); #1;
    acc_in = pack4(5, -7, 300, -300);
    start  = 1'b1;
    ready  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    chk("midreset_queue_left", exp_q.size(), 2);
    exp_q.delete();
    chk_idle_outputs("midreset_async");
    @(negedge clk);
    chk_idle_outputs("midreset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    // Fresh snapshot after reset, exact saturation boundaries.
    push(0, -1, 0, 0, 0);
    push(255, 255, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    drain(pack4(-1, 255, 256, -256), 0, 1'b0, 1'b1, "post_reset");

    // Back-to-back: second start in the IDLE cycle right after done.
    push(5, 5, 0, 0, 0);
    push(0, -7, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    drain(pack4(5, -7, 300, -300), 0, 1'b0, 1'b0, "b2b_first");
    push(0, -256, 0, 0, 0);
    push(0, 0, 0, 1, 0);
    push(255, 255, 1, 0, 0);
    push(0, -256, 1, 1, 1);
    drain(pack4(-300, 0, 65535, -65536), 0, 1'b0, 1'b1, "b2b_second");

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
